// File: rtl/work_time_monitor.sv
// Accumulates operating seconds while the hood is in an active gear, drives an hh:mm BCD display
// and raises a cleaning reminder once the accumulated time reaches a loadable limit.
module work_time_monitor #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter logic [31:0] DEFAULT_LIMIT = 32'd36000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  state_in,
  input  logic        clean_done,
  input  logic [31:0] limit_in,
  input  logic        limit_load,
  output logic [31:0] work_time,
  output logic        sec_tick,
  output logic [7:0]  hh_bcd,
  output logic [7:0]  mm_bcd,
  output logic        reminder
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [5:0]    sec_cnt;
  logic [31:0]   limit;
  logic          active;
  logic          wrap;
  logic          disp_full;

  assign active    = (state_in == 3'd1) || (state_in == 3'd2) || (state_in == 3'd3);
  assign wrap      = active && (presc == PMAX);
  assign disp_full = (hh_bcd == 8'h99) && (mm_bcd == 8'h59) && (sec_cnt == 6'd59);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc     <= '0;
      work_time <= '0;
      sec_cnt   <= '0;
      hh_bcd    <= 8'h00;
      mm_bcd    <= 8'h00;
      sec_tick  <= 1'b0;
      reminder  <= 1'b0;
      limit     <= DEFAULT_LIMIT;
    end else begin
      // A zero limit would assert the reminder permanently, so it is dropped.
      if (limit_load && (limit_in != 32'd0)) limit <= limit_in;

      if (clean_done) begin
        presc     <= '0;
        work_time <= '0;
        sec_cnt   <= '0;
        hh_bcd    <= 8'h00;
        mm_bcd    <= 8'h00;
        sec_tick  <= 1'b0;
        reminder  <= 1'b0;
      end else begin
        sec_tick <= wrap;
        if (active) presc <= wrap ? '0 : presc + PW'(1);

        if (wrap) begin
          if (work_time != 32'hFFFF_FFFF) work_time <= work_time + 32'd1;
          // The display stops at 99:59:59 while work_time keeps running.
          if (!disp_full) begin
            if (sec_cnt == 6'd59) begin
              sec_cnt <= '0;
              if (mm_bcd == 8'h59) begin
                mm_bcd <= 8'h00;
                hh_bcd <= bcd_inc(hh_bcd);
              end else begin
                mm_bcd <= bcd_inc(mm_bcd);
              end
            end else begin
              sec_cnt <= sec_cnt + 6'd1;
            end
          end
        end

        if (work_time >= limit) reminder <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_work_time_monitor.sv
// Directed bench for work_time_monitor with a 4-cycle second.
module tb_work_time_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  state_in;
  logic        clean_done;
  logic [31:0] limit_in;
  logic        limit_load;
  logic [31:0] work_time;
  logic        sec_tick;
  logic [7:0]  hh_bcd;
  logic [7:0]  mm_bcd;
  logic        reminder;

  int total = 0;
  int bad   = 0;

  work_time_monitor #(.TICKS_PER_SEC(4), .DEFAULT_LIMIT(32'd36000)) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .clean_done(clean_done),
    .limit_in(limit_in), .limit_load(limit_load), .work_time(work_time),
    .sec_tick(sec_tick), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .reminder(reminder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    state_in = 3'd0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; state_in = 3'd0; clean_done = 1'b0; limit_in = '0; limit_load = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("rst_nox", 32'($isunknown({work_time, sec_tick, hh_bcd, mm_bcd, reminder})), 0);
    check("rst_wt", work_time, 0);
    check("rst_tick", 32'(sec_tick), 0);
    check("rst_hh", 32'(hh_bcd), 0);
    check("rst_mm", 32'(mm_bcd), 0);
    check("rst_rem", 32'(reminder), 0);

    // Gear one for 12 cycles: ticks on cycles 4, 8, 12.
    state_in = 3'd1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("g1_tick%0d", k), 32'(sec_tick), 32'((k % 4) == 0));
    end
    check("g1_wt", work_time, 3);

    // Pause in clean mode keeps the partial second.
    do_reset();
    state_in = 3'd2; step(6);
    check("pause_wt_a", work_time, 1);
    state_in = 3'd4; step(10);
    check("pause_wt_b", work_time, 1);
    check("pause_tick", 32'(sec_tick), 0);
    state_in = 3'd2; step(1);
    check("pause_wt_c", work_time, 1);
    step(1);
    check("pause_wt_d", work_time, 2);
    check("pause_tick2", 32'(sec_tick), 1);

    // Limit 5, turbo for 20 cycles.
    do_reset();
    limit_in = 32'd5; limit_load = 1'b1; state_in = 3'd3;
    step(1);
    limit_load = 1'b0;
    step(19);
    check("lim_wt", work_time, 5);
    check("lim_rem_a", 32'(reminder), 0);
    state_in = 3'd0; step(1);
    check("lim_rem_b", 32'(reminder), 1);
    limit_in = 32'd0; limit_load = 1'b1; step(1); limit_load = 1'b0;

    // Clean on a second boundary.
    state_in = 3'd3; step(3);
    clean_done = 1'b1; step(1); clean_done = 1'b0;
    check("cln_wt", work_time, 0);
    check("cln_rem", 32'(reminder), 0);
    check("cln_tick", 32'(sec_tick), 0);
    check("cln_hh", 32'(hh_bcd), 0);
    check("cln_mm", 32'(mm_bcd), 0);

    // Limit stayed 5 after the zero load.
    step(20);
    check("lim0_wt", work_time, 5);
    check("lim0_rem_a", 32'(reminder), 0);
    step(1);
    check("lim0_rem_b", 32'(reminder), 1);

    // Raising the limit leaves the reminder set.
    limit_in = 32'd100; limit_load = 1'b1; step(1); limit_load = 1'b0;
    step(2);
    check("raise_rem", 32'(reminder), 1);

    // Clean together with a limit load: both take effect.
    state_in = 3'd0;
    clean_done = 1'b1; limit_in = 32'd3; limit_load = 1'b1; step(1);
    clean_done = 1'b0; limit_load = 1'b0;
    check("cl_ld_wt", work_time, 0);
    check("cl_ld_rem", 32'(reminder), 0);
    state_in = 3'd3; step(12);
    check("cl_ld_wt3", work_time, 3);
    check("cl_ld_rem_a", 32'(reminder), 0);
    step(1);
    check("cl_ld_rem_b", 32'(reminder), 1);

    // Display: 10 minutes, then one hour.
    do_reset();
    state_in = 3'd1;
    step(600 * 4);
    check("disp10_mm", 32'(mm_bcd), 32'h10);
    check("disp10_hh", 32'(hh_bcd), 32'h00);
    step(3000 * 4);
    check("disp1h_hh", 32'(hh_bcd), 32'h01);
    check("disp1h_mm", 32'(mm_bcd), 32'h00);
    check("disp1h_wt", work_time, 3600);

    // Jump the display close to its ceiling.
    force dut.hh_bcd = 8'h99;
    force dut.mm_bcd = 8'h59;
    force dut.sec_cnt = 6'd57;
    #1;
    release dut.hh_bcd;
    release dut.mm_bcd;
    release dut.sec_cnt;
    step(12);
    check("sat_hh", 32'(hh_bcd), 32'h99);
    check("sat_mm", 32'(mm_bcd), 32'h59);
    check("sat_wt_a", work_time, 3603);
    step(8);
    check("sat_hh2", 32'(hh_bcd), 32'h99);
    check("sat_mm2", 32'(mm_bcd), 32'h59);
    check("sat_wt_b", work_time, 3605);

    // work_time saturation.
    force dut.work_time = 32'hFFFF_FFFE;
    #1;
    release dut.work_time;
    step(4);
    check("wsat_a", work_time, 32'hFFFF_FFFF);
    step(4);
    check("wsat_b", work_time, 32'hFFFF_FFFF);
    check("wsat_tick", 32'(sec_tick), 1);

    // Reset mid-second with work_time 7, prescaler 2, limit 5.
    do_reset();
    limit_in = 32'd5; limit_load = 1'b1; state_in = 3'd1; step(1); limit_load = 1'b0;
    step(29);
    check("pre_wt", work_time, 7);
    check("pre_rem", 32'(reminder), 1);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    check("rst2_wt", work_time, 0);
    check("rst2_rem", 32'(reminder), 0);
    check("rst2_hhmm", {16'h0, hh_bcd, mm_bcd}, 0);
    step(3);
    check("rst2_wt3", work_time, 0);
    step(1);
    check("rst2_wt4", work_time, 1);
    check("rst2_tick", 32'(sec_tick), 1);
    // Default limit back at 36000.
    force dut.work_time = 32'd35999;
    #1;
    release dut.work_time;
    step(4);
    check("dflt_wt", work_time, 36000);
    check("dflt_rem_a", 32'(reminder), 0);
    step(1);
    check("dflt_rem_b", 32'(reminder), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
